// File: rtl/transmitter_buffer.sv
// transmitter_buffer: wraps a payload in START/slice-index/END bytes and shifts it out LSB first,
// one bit per modulator tick, followed by an idle gap of GAP_BITS ticks.
module transmitter_buffer #(
    parameter int         DATA_WIDTH     = 48,
    parameter int         INDEX_WIDTH    = 8,
    parameter int         NETWORK_SLICES = 4,
    parameter logic [7:0] START_CHAR     = 8'h7E,
    parameter logic [7:0] END_CHAR       = 8'h81,
    parameter int         GAP_BITS       = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] sys_packet,
    input  logic                  load,
    output logic                  ready,
    input  logic                  tick,
    input  logic                  abort,
    output logic                  data_stream,
    output logic                  tx_active,
    output logic                  done
);
    localparam int FRAME_W = DATA_WIDTH + INDEX_WIDTH + 16;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int GAP_W   = $clog2(GAP_BITS + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [BIT_W-1:0]       BIT_LAST  = BIT_W'(FRAME_W - 1);
    localparam logic [GAP_W-1:0]       GAP_LAST  = GAP_W'(GAP_BITS - 1);
    localparam logic [INDEX_WIDTH-1:0] SLICE_MAX = INDEX_WIDTH'(NETWORK_SLICES - 1);

    logic [1:0]             state_q, state_d;
    logic [FRAME_W-1:0]     shift_q, shift_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic [INDEX_WIDTH-1:0] slice_q, slice_d;
    logic                   done_q, done_d;

    assign ready       = state_q == IDLE;
    assign tx_active   = state_q == SEND;
    assign data_stream = tx_active & shift_q[0];
    assign done        = done_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        slice_d   = slice_q;
        done_d    = 1'b0;
        if (state_q == IDLE) begin
            // abort takes priority over a simultaneous load
            if (load && !abort) begin
                state_d   = SEND;
                shift_d   = {END_CHAR, sys_packet, slice_q, START_CHAR};
                bit_cnt_d = '0;
                slice_d   = (slice_q == SLICE_MAX) ? '0 : slice_q + 1'b1;
            end
        end else if (abort) begin
            state_d   = IDLE;
            shift_d   = '0;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
        end else if (tick && state_q == SEND) begin
            shift_d = shift_q >> 1;
            if (bit_cnt_q == BIT_LAST) begin
                state_d   = GAP;
                done_d    = 1'b1;
                gap_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end else if (tick) begin
            if (gap_cnt_q == GAP_LAST) state_d = IDLE;
            else gap_cnt_d = gap_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            slice_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            slice_q   <= slice_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_transmitter_buffer.sv
// tb_transmitter_buffer: directed frame vectors plus abort, reset and idle corner sequences.
module tb_transmitter_buffer;
    logic        clk, reset_n, load, tick, abort;
    logic [47:0] sys_packet;
    logic        ready, data_stream, tx_active, done;
    int          n_vec = 0, n_miss = 0, done_cnt = 0;

    transmitter_buffer dut (
        .clk(clk), .reset_n(reset_n), .sys_packet(sys_packet), .load(load), .ready(ready),
        .tick(tick), .abort(abort), .data_stream(data_stream), .tx_active(tx_active), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    typedef struct {
        logic [47:0] pkt;
        int          sp;
        bit          poke;
        logic [71:0] exp;
    } vec_t;
    vec_t tv [5];

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic run_frame(input logic [47:0] pkt, input logic [71:0] exp, input int sp,
                             input bit poke, input string nm);
        logic [71:0] cap;
        int          unstable, d0;
        cap = '0;
        unstable = 0;
        chk({nm, "_ready_idle"}, 72'(ready), 72'd1);
        sys_packet = pkt;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        sys_packet = '0;
        d0 = done_cnt;
        chk({nm, "_tx_active"}, 72'({tx_active, ready}), 72'b10);
        for (int i = 0; i < 72; i++) begin
            cap[i] = data_stream;
            for (int k = 1; k < sp; k++) begin
                @(negedge clk);
                if (data_stream !== cap[i]) unstable++;
            end
            if (poke && i == 10) begin
                load = 1'b1;
                sys_packet = '1;
                @(negedge clk);
                load = 1'b0;
                sys_packet = '0;
                if (data_stream !== cap[i]) unstable++;
            end
            pulse_tick();
        end
        chk({nm, "_done_after_last"}, 72'({done, tx_active, ready, data_stream}), 72'b1000);
        for (int g = 0; g < 8; g++) begin
            if (poke && g == 3) begin
                load = 1'b1;
                @(negedge clk);
                load = 1'b0;
            end
            if (g == 7) chk({nm, "_gap_not_ready"}, 72'({ready, data_stream}), 72'b00);
            pulse_tick();
        end
        chk({nm, "_ready_after_gap"}, 72'({ready, tx_active, done}), 72'b100);
        chk({nm, "_done_count"}, 72'(done_cnt - d0), 72'd1);
        chk({nm, "_frame"}, cap, exp);
        chk({nm, "_stable"}, 72'(unstable), 72'd0);
    endtask

    initial begin
        int d0;
        reset_n = 1'b0; load = 1'b0; tick = 1'b0; abort = 1'b0; sys_packet = '0;
        tv[0] = '{48'hA5A5_0000_FFFF, 1,  1'b0, 72'h81_A5A50000FFFF_00_7E};
        tv[1] = '{48'h0123_4567_89AB, 1,  1'b1, 72'h81_0123456789AB_01_7E};
        tv[2] = '{48'hA5A5_0000_FFFF, 17, 1'b0, 72'h81_A5A50000FFFF_02_7E};
        tv[3] = '{48'hFFFF_FFFF_FFFF, 3,  1'b1, 72'h81_FFFFFFFFFFFF_03_7E};
        tv[4] = '{48'h0000_0000_0000, 3,  1'b0, 72'h81_000000000000_00_7E};
        #3;
        chk("reset_outputs", 72'({ready, data_stream, tx_active, done}), 72'b1000);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int v = 0; v < 5; v++) run_frame(tv[v].pkt, tv[v].exp, tv[v].sp, tv[v].poke, $sformatf("vec%0d", v));

        // mid-frame reset: bit 40 of an all-ones payload frame is 1 when reset hits
        sys_packet = 48'hFFFF_FFFF_FFFF;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 40; i++) pulse_tick();
        chk("pre_reset_bit", 72'({data_stream, tx_active}), 72'b11);
        d0 = done_cnt;
        #2 reset_n = 1'b0;
        #1 chk("async_reset", 72'({ready, data_stream, tx_active, done}), 72'b1000);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_no_done", 72'(done_cnt - d0), 72'd0);
        run_frame(48'h1234_5678_9ABC, 72'h81_123456789ABC_00_7E, 1, 1'b0, "post_reset");

        // abort after 20 ticks from a fresh slice counter
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        sys_packet = 48'hDEAD_BEEF_0001;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 20; i++) pulse_tick();
        d0 = done_cnt;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", 72'({data_stream, tx_active, ready}), 72'b001);
        @(negedge clk);
        chk("abort_no_done", 72'(done_cnt - d0), 72'd0);
        abort = 1'b1;
        load = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        load = 1'b0;
        chk("abort_beats_load", 72'({ready, tx_active}), 72'b10);
        pulse_tick();
        chk("idle_tick", 72'({ready, data_stream, tx_active, done}), 72'b1000);
        run_frame(48'h0F0F_F0F0_3C3C, 72'h81_0F0FF0F03C3C_01_7E, 1, 1'b0, "post_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/transmitter_buffer.md
TRANSMITTER_BUFFER -- requirements
Module: transmitter_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 48: payload bits per packet.
REQ-002 SHALL have parameter INDEX_WIDTH, default 8: slice-index field width.
REQ-003 SHALL have parameter NETWORK_SLICES, default 4: slice-index modulus, at most 2**INDEX_WIDTH.
REQ-004 SHALL have parameter START_CHAR, default 8'h7E: frame start byte.
REQ-005 SHALL have parameter END_CHAR, default 8'h81: frame end byte.
REQ-006 SHALL have parameter GAP_BITS, default 8: idle bits sent between frames, at least 1.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-009 SHALL have port sys_packet, input, DATA_WIDTH bits: payload to send.
REQ-010 SHALL have port load, input, 1 bit: sys_packet valid; accepted when load && ready.
REQ-011 SHALL have port ready, output, 1 bit: block can accept a packet.
REQ-012 SHALL have port tick, input, 1 bit: one-cycle modulator strobe to advance one bit.
REQ-013 SHALL have port abort, input, 1 bit: synchronous abandon of the current frame.
REQ-014 SHALL have port data_stream, output, 1 bit: serial bit to the modulator.
REQ-015 SHALL have port tx_active, output, 1 bit: high while frame bits (not gap bits) are driven.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse after the last frame bit.

Function
REQ-017 SHALL define FRAME_W = DATA_WIDTH + INDEX_WIDTH + 16.
- Frame layout: frame[7:0]=START_CHAR; frame[15:8]=slice index; frame[15+INDEX_WIDTH:16] assumed wrong if INDEX_WIDTH≠8, so precisely: frame[8+INDEX_WIDTH-1:8]=slice index; frame[8+INDEX_WIDTH+DATA_WIDTH-1:8+INDEX_WIDTH]=sys_packet; frame[FRAME_W-1:FRAME_W-8]=END_CHAR.
REQ-018 SHALL serialize LSB first: frame[0] first, frame[FRAME_W-1] last, so a shift-in receiver sees START_CHAR in its low byte and END_CHAR in its high byte.
REQ-019 SHALL implement states IDLE, SEND, GAP.
REQ-020 IDLE: ready=1, data_stream=0, tx_active=0; tick ignored.
- On load&&ready: latch frame into shift register, bit counter=0, go to SEND next cycle.
REQ-021 SEND: data_stream=current shift-register LSB, tx_active=1, ready=0.
- data_stream = frame[0] in the first SEND cycle, before any tick.
- Each tick shifts one bit and increments the counter.
- A tick while counter==FRAME_W-1 goes to GAP, pulses done for exactly that transition cycle, and loads the gap counter=0.
REQ-022 GAP: data_stream=0, tx_active=0, ready=0.
- Each tick increments the gap counter; a tick at GAP_BITS-1 goes to IDLE.
REQ-023 Slice counter: reset 0; increments on each accepted load; wraps from NETWORK_SLICES-1 to 0.
- The value before increment is inserted into the frame.
REQ-024 load while ready=0 SHALL be ignored (no buffering, no counter change).
REQ-025 abort in SEND or GAP SHALL go to IDLE next cycle with data_stream=0 and no done pulse.
- Slice counter unchanged.
- abort in IDLE has no effect.
- abort && load in the same IDLE cycle: abort wins, packet not accepted.
REQ-026 tick with no state change pending (IDLE) SHALL not alter any output.
REQ-027 Counters SHALL be sized ceil(log2(FRAME_W)) and ceil(log2(GAP_BITS+1)) bits.
- No wrap beyond terminal counts.

Reset
REQ-028 reset_n low SHALL asynchronously force: state IDLE, ready=1, data_stream=0, tx_active=0, done=0, slice counter=0, shift register=0, bit and gap counters=0.
REQ-029 Reset asserted mid-frame SHALL truncate the frame immediately with no done pulse.
- Operation resumes from IDLE on the first clk edge after release.

Verification
REQ-030 Defaults; load with sys_packet=48'hA5A5_0000_FFFF, then 72 ticks.
- Captured bits [7:0]=8'h7E, [15:8]=8'h00, [63:16]=48'hA5A5_0000_FFFF, [71:64]=8'h81.
- done high one cycle after the 72nd tick; ready rises after 8 further ticks.
REQ-031 Five back-to-back packets: index fields read 0,1,2,3,0.
REQ-032 load pulsed during SEND and GAP: ignored; slice counter and captured stream unchanged.
REQ-033 abort after 20 ticks: data_stream=0, tx_active=0, ready=1 next cycle; no done; next frame index=1.
REQ-034 reset_n pulsed low after 40 ticks: all outputs at reset values without a clk edge.
- Next accepted frame carries index 0.
REQ-035 Ticks spaced 1, 3 and 17 cycles apart: identical bit sequence; data_stream stable between ticks.
